// File: rtl/ising_loop.sv
// ising_loop: single-chain Ising sampler core.
// Holds N one-bit spins (1 = +1, 0 = -1) and an N x N signed coupling matrix J.
// A sweep computes h = J*s one row per cycle, publishes h on matrix_output
// with a one-cycle valid pulse, then sets every spin to sign(h_i).
// Optional build macro: ISING_NOISE_EN adds a 16-bit LFSR that perturbs the
// spin decision (h_i + n_i >= 0). matrix_output always carries the noise-free h.
module ising_loop #(
    parameter int N        = 4,
    parameter int DATABITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         readySignal,
    output logic signed [DATABITS*N-1:0] matrix_output,
    output logic                         valid
);

    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [DATABITS-1:0] J_POS = DATABITS'(1);
    localparam logic signed [DATABITS-1:0] J_NEG = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t                      state_reg;
    logic        [ROW_W-1:0]     row_reg;
    logic        [N-1:0]         spin_reg;
    logic        [N-1:0]         spin_next;
    logic                        valid_reg;
    logic signed [DATABITS-1:0]  j_reg     [N][N];
    logic signed [DATABITS-1:0]  h_buf_reg [N];
    logic signed [DATABITS-1:0]  out_reg   [N];
    logic signed [DATABITS-1:0]  row_sum;

`ifdef ISING_NOISE_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Fibonacci feedback for taps 16,14,13,11 (bit indices 15,13,12,10).
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
`endif

    // Local field of the current row: add or subtract each coupling according
    // to the spin bit, so no multiplier is needed. Wraps at DATABITS.
    always_comb begin
        row_sum = '0;
        for (int j = 0; j < N; j++) begin
            if (spin_reg[j]) begin
                row_sum = row_sum + j_reg[row_reg][j];
            end else begin
                row_sum = row_sum - j_reg[row_reg][j];
            end
        end
    end

    // Per-spin decision for the update edge, plus output lane packing.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
`ifdef ISING_NOISE_EN
            logic signed [3:0]        noise_slice;
            logic signed [DATABITS:0] noisy_sum;

            assign noise_slice = lfsr_reg[4*(gi%4) +: 4];
            // One extra bit keeps h + n from wrapping before the sign test.
            assign noisy_sum   = {h_buf_reg[gi][DATABITS-1], h_buf_reg[gi]}
                               + {{(DATABITS-3){noise_slice[3]}}, noise_slice};
            assign spin_next[gi] = ~noisy_sum[DATABITS];
`else
            // h >= 0 maps to +1, so a zero field resolves to +1.
            assign spin_next[gi] = ~h_buf_reg[gi][DATABITS-1];
`endif
            assign matrix_output[DATABITS*gi +: DATABITS] = out_reg[gi];
        end
    endgenerate

    assign valid = valid_reg;

    // Sweep controller: IDLE waits for a request, COMPUTE fills one h row per
    // cycle, UPDATE publishes h and commits the new spins in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            spin_reg  <= '1;
            valid_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
                h_buf_reg[i] <= '0;
                out_reg[i]   <= '0;
                for (int j = 0; j < N; j++) begin
                    j_reg[i][j] <= (i == j)             ? '0    :
                                   (((i + j) % 2) == 0) ? J_POS : J_NEG;
                end
            end
`ifdef ISING_NOISE_EN
            lfsr_reg <= 16'hACE1;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (readySignal) begin
                        row_reg   <= '0;
                        state_reg <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // Spins stay frozen until UPDATE, so every row sees the
                    // spin vector latched at sweep start.
                    h_buf_reg[row_reg] <= row_sum;
                    if (row_reg == ROW_W'(N - 1)) begin
                        row_reg   <= '0;
                        state_reg <= UPDATE;
                    end else begin
                        row_reg <= row_reg + ROW_W'(1);
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        out_reg[i] <= h_buf_reg[i];
                    end
                    valid_reg <= 1'b1;
                    spin_reg  <= spin_next;
`ifdef ISING_NOISE_EN
                    lfsr_reg  <= {lfsr_reg[14:0], lfsr_fb};
`endif
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ising_loop.sv
// Directed testbench for ising_loop with N=4, DATABITS=16 (default build).
// With the reset J and all spins +1 every h_i is -1; with all spins -1 every
// h_i is +1, so successive sweeps alternate between the two.
module tb_ising_loop;

    localparam int N        = 4;
    localparam int DATABITS = 16;

    logic                         clk;
    logic                         rst;
    logic                         readySignal;
    logic signed [DATABITS*N-1:0] matrix_output;
    logic                         valid;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [63:0] LANES_NEG  = {4{16'hFFFF}};
    localparam logic [63:0] LANES_POS  = {4{16'h0001}};
    localparam logic [63:0] LANES_ZERO = 64'h0;

    ising_loop #(.N(N), .DATABITS(DATABITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .readySignal   (readySignal),
        .matrix_output (matrix_output),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One full sweep from idle: request at edge k, valid expected only after
    // edge k+N+1. mid_pulse raises readySignal during COMPUTE to prove it is ignored.
    task automatic run_sweep(input string tag, input logic [63:0] exp_lanes,
                             input logic [3:0] exp_spins, input bit mid_pulse);
        readySignal = 1'b1;
        tick();
        for (int c = 1; c <= N + 1; c++) begin
            readySignal = (mid_pulse && (c == 2));
            tick();
            check({tag, "_valid"}, 64'(valid), 64'(c == N + 1));
        end
        readySignal = 1'b0;
        check({tag, "_lanes"}, matrix_output, exp_lanes);
        check({tag, "_spins"}, 64'(dut.spin_reg), 64'(exp_spins));
        $display("sweep %s: lanes=%h spins=%b", tag, matrix_output, dut.spin_reg);
        tick();
        check({tag, "_valid_drop"}, 64'(valid), 64'h0);
        check({tag, "_hold"}, matrix_output, exp_lanes);
    endtask

    initial begin
        rst         = 1'b1;
        readySignal = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_lanes", matrix_output, LANES_ZERO);
        check("reset_valid", 64'(valid), 64'h0);
        check("reset_spins", 64'(dut.spin_reg), 64'hF);
        $display("reset: lanes=%h valid=%b spins=%b", matrix_output, valid, dut.spin_reg);

        // Idle with no request: nothing may happen.
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_valid", 64'(valid), 64'h0);
        end
        check("idle_lanes", matrix_output, LANES_ZERO);
        check("idle_spins", 64'(dut.spin_reg), 64'hF);
        $display("idle: lanes=%h spins=%b", matrix_output, dut.spin_reg);

        // First sweep flips everything to -1, second back to +1, third to -1.
        run_sweep("sweep1", LANES_NEG, 4'h0, 1'b0);
        run_sweep("sweep2", LANES_POS, 4'hF, 1'b0);
        run_sweep("sweep3_midreq", LANES_NEG, 4'h0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midreq_no_extra_valid", 64'(valid), 64'h0);
        end

        // Reset landing while COMPUTE is on row 2.
        readySignal = 1'b1;
        tick();
        readySignal = 1'b0;
        tick();
        tick();
        check("pre_rst_row", 64'(dut.row_reg), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 64'(dut.state_reg), 64'd0);
        check("midrst_lanes", matrix_output, LANES_ZERO);
        check("midrst_spins", 64'(dut.spin_reg), 64'hF);
        check("midrst_valid", 64'(valid), 64'h0);
        $display("mid-sweep reset: lanes=%h spins=%b", matrix_output, dut.spin_reg);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midrst_no_valid", 64'(valid), 64'h0);
        end

        // Request held high for 20 edges: back-to-back sweeps every N+2 cycles.
        for (int t = 0; t < 26; t++) begin
            readySignal = (t < 20);
            tick();
            check("held_valid", 64'(valid), 64'((t % 6) == 5));
            if ((t % 6) == 5) begin
                check("held_lanes", matrix_output, (((t / 6) % 2) == 0) ? LANES_NEG : LANES_POS);
                $display("held sweep at t=%0d: lanes=%h", t, matrix_output);
            end
        end
        readySignal = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
